dfir_interpolate: RTL and testbench
===================================

DFIR_INTERPOLATE -- requirements
Module: dfir_interpolate

Interface
REQ-001 Parameter DATA_WIDTH, 24, sample width in bits.
REQ-002 Parameter DFIR_MAX_CHANNELS, 2, number of valid channel indices.
REQ-003 Parameter DFIR_MAX_ICEF, 5, maximum interpolation factor L.
REQ-004 Parameter DFIR_CONFIG_DATA_WIDTH, 24, config word width.
REQ-005 Parameter DFIR_ICEF_DEFAULT, DFIR_MAX_ICEF, L after reset.
REQ-006 CLK  in  1  clock; all state on rising edge.
REQ-007 nRST  in  1  reset, asynchronous, active-low.
REQ-008 isConfig  in  1  config request.
REQ-009 isConfigDone  out  1  one-cycle config-complete pulse.
REQ-010 Data_Config_In  in  DFIR_CONFIG_DATA_WIDTH  new L value.
REQ-011 Data_In  in  DATA_WIDTH  signed input sample.
REQ-012 Data_In_Valid  in  1  input qualifier.
REQ-013 Data_In_ChIdx  in  4  input channel index.
REQ-014 Data_In_Ready  out  1  block accepts input this cycle.
REQ-015 Data_Out  out  DATA_WIDTH  signed output sample.
REQ-016 Data_Out_Valid  out  1  output qualifier.
REQ-017 Data_Out_ChIdx  out  4  output channel index.
REQ-018 Data_Out_Ready  in  1  downstream accepts output.

Function
REQ-019 Config FSM SHALL have states RST(0), CFG(1), DONE(2), RUN(3); any other encoding SHALL go to RST next cycle.
REQ-020 RST->CFG and RUN->CFG on isConfig=1; CFG->DONE and DONE->RUN unconditionally.
REQ-021 In CFG, L SHALL latch Data_Config_In, clamped: 0 -> 1, >DFIR_MAX_ICEF -> DFIR_MAX_ICEF.
REQ-022 isConfigDone SHALL be 1 only during the DONE cycle.
REQ-023 Emit engine SHALL process input only while the config FSM is in RST or RUN; in CFG/DONE, Data_In_Ready=0.
REQ-024 Entering CFG SHALL abort any partial burst: emit engine to IDLE, Data_Out_Valid=0 the next cycle.
REQ-025 Emit engine states: IDLE, EMIT; handshake completes when Valid and Ready are both 1 in the same cycle.
REQ-026 Data_In_Ready = 1 in IDLE, or in EMIT when the final phase (L-1) is being accepted by downstream this cycle.
REQ-027 On input accept, the block SHALL capture the sample and channel index, reset phase to 0, and enter EMIT; Data_Out_Valid SHALL rise the next cycle (latency 1).
REQ-028 In EMIT, phase 0 output SHALL equal the captured sample; phases 1..L-1 SHALL be per REQ-040/041.
REQ-029 On each output handshake, phase SHALL increment; after phase L-1 the engine returns to IDLE unless a new input is accepted in the same cycle (back-to-back, no bubble).
REQ-030 While Data_Out_Valid=1 and Data_Out_Ready=0, Data_Out, Data_Out_ChIdx, and Data_Out_Valid SHALL hold stable.
REQ-031 Data_Out_ChIdx SHALL equal the captured index for all L outputs of a burst.
REQ-032 An input with Data_In_ChIdx >= DFIR_MAX_CHANNELS SHALL be accepted and discarded with no output.
REQ-033 L=1 SHALL act as a registered pass-through: one output per input.
REQ-034 With Data_Out_Ready held at 1, sustained throughput SHALL be one input per L cycles.
REQ-035 All outputs SHALL be registered; no combinational path from Data_In to Data_Out.

Reset
REQ-036 On nRST=0: config FSM in RST, L=DFIR_ICEF_DEFAULT, emit engine in IDLE, phase=0.
REQ-037 Reset values: isConfigDone=0, Data_Out=0, Data_Out_Valid=0, Data_Out_ChIdx=0, Data_In_Ready=0 (1 from the first cycle after release).
REQ-038 Reset asserted mid-burst SHALL immediately drop Data_Out_Valid; no remaining phases are emitted after release.
REQ-039 Deassertion SHALL be synchronized to CLK internally; no asynchronous clocking of data registers.

Configuration
REQ-040 Macro DFIR_INTERP_HOLD_EN defined: phases 1..L-1 SHALL repeat the captured sample (zero-order hold).
REQ-041 DFIR_INTERP_HOLD_EN undefined: phases 1..L-1 SHALL output 0 (zero-stuffing); Valid/ChIdx timing is identical in both builds.

Verification
REQ-042 Reset, then L=3 via config; input 0x000100 on ch0 with Ready=1 -> isConfigDone pulses 1 cycle; outputs 0x000100, 0x000000, 0x000000 (hold build: three 0x000100), ChIdx=0.
REQ-043 L=4, Data_Out_Ready toggled 1,0,1,0... -> exactly 4 outputs; Data_Out stable on every stalled cycle; Data_In_Ready=0 until the final phase handshake.
REQ-044 L=2, continuous inputs alternating ch0/ch1 with Ready=1 -> Data_Out_Valid stays 1 continuously; ChIdx pattern 0,0,1,1,...; one input every 2 cycles.
REQ-045 Config Data_Config_In=0, then =9 -> effective L=1 (pass-through), then L=5 (clamped).
REQ-046 isConfig asserted at phase 1 of an L=5 burst -> Valid drops, no further outputs; after DONE, the next input emits a full burst at the new L.
REQ-047 Input with ChIdx=7 -> accepted (Ready=1), no Data_Out_Valid; nRST pulsed mid-burst -> all outputs return to 0 at once.

Source files
------------

// File: rtl/dfir_interpolate.sv
// Interpolation-by-L front end: each accepted sample becomes an L-phase output burst.
// Build option DFIR_INTERP_HOLD_EN: phases 1..L-1 repeat the sample; otherwise they are zero.
`default_nettype none

module dfir_interpolate #(
  parameter int DATA_WIDTH             = 24,
  parameter int DFIR_MAX_CHANNELS      = 2,
  parameter int DFIR_MAX_ICEF          = 5,
  parameter int DFIR_CONFIG_DATA_WIDTH = 24,
  parameter int DFIR_ICEF_DEFAULT      = DFIR_MAX_ICEF
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              isConfig,
  output logic                              isConfigDone,
  input  logic [DFIR_CONFIG_DATA_WIDTH-1:0] Data_Config_In,
  input  logic [DATA_WIDTH-1:0]             Data_In,
  input  logic                              Data_In_Valid,
  input  logic [3:0]                        Data_In_ChIdx,
  output logic                              Data_In_Ready,
  output logic [DATA_WIDTH-1:0]             Data_Out,
  output logic                              Data_Out_Valid,
  output logic [3:0]                        Data_Out_ChIdx,
  input  logic                              Data_Out_Ready
);

  localparam int LW = $clog2(DFIR_MAX_ICEF + 1);

  typedef enum logic [1:0] {
    CFG_RST  = 2'd0,
    CFG_CFG  = 2'd1,
    CFG_DONE = 2'd2,
    CFG_RUN  = 2'd3
  } cfg_state_t;

  typedef enum logic {
    EM_IDLE = 1'b0,
    EM_EMIT = 1'b1
  } emit_state_t;

  logic        rst_meta;
  logic        rst_n;
  logic        run_en;
  cfg_state_t  cfg_state;
  emit_state_t emit_state;
  logic [LW-1:0] l_reg;
  logic [LW-1:0] l_clamped;
  logic [LW-1:0] phase;
  logic        run_ok;
  logic        abort;
  logic        last;
  logic        hs;
  logic        accept;
  logic        ch_ok;

  // Async assert, sync release; run_en mirrors rst_n so the ready gate is not a reset net.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
      run_en   <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
      run_en   <= rst_meta;
    end
  end

  always_comb begin
    l_clamped = Data_Config_In[LW-1:0];
    if (Data_Config_In == '0)
      l_clamped = LW'(1);
    else if (Data_Config_In > DFIR_CONFIG_DATA_WIDTH'(DFIR_MAX_ICEF))
      l_clamped = LW'(DFIR_MAX_ICEF);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cfg_state    <= CFG_RST;
      l_reg        <= LW'(DFIR_ICEF_DEFAULT);
      isConfigDone <= 1'b0;
    end else begin
      isConfigDone <= (cfg_state == CFG_CFG);
      case (cfg_state)
        CFG_RST, CFG_RUN: if (isConfig) cfg_state <= CFG_CFG;
        CFG_CFG: begin
          cfg_state <= CFG_DONE;
          l_reg     <= l_clamped;
        end
        CFG_DONE: cfg_state <= CFG_RUN;
        default:  cfg_state <= CFG_RST;
      endcase
    end
  end

  assign run_ok         = run_en && (cfg_state == CFG_RST || cfg_state == CFG_RUN);
  assign abort          = run_ok && isConfig;
  assign Data_Out_Valid = (emit_state == EM_EMIT);
  assign hs             = Data_Out_Valid && Data_Out_Ready;
  assign last           = (phase == l_reg - LW'(1));
  assign Data_In_Ready  = run_ok && !isConfig && (emit_state == EM_IDLE || (hs && last));
  assign accept         = Data_In_Valid && Data_In_Ready;
  assign ch_ok          = int'(Data_In_ChIdx) < DFIR_MAX_CHANNELS;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      emit_state     <= EM_IDLE;
      phase          <= '0;
      Data_Out       <= '0;
      Data_Out_ChIdx <= '0;
    end else if (abort) begin
      emit_state <= EM_IDLE;
      phase      <= '0;
    end else if (accept) begin
      phase <= '0;
      if (ch_ok) begin
        emit_state     <= EM_EMIT;
        Data_Out       <= Data_In;
        Data_Out_ChIdx <= Data_In_ChIdx;
      end else begin
        emit_state <= EM_IDLE;
      end
    end else if (hs) begin
      if (last) begin
        emit_state <= EM_IDLE;
        phase      <= '0;
      end else begin
        phase <= phase + LW'(1);
`ifdef DFIR_INTERP_HOLD_EN
        Data_Out <= Data_Out;
`else
        Data_Out <= '0;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfir_interpolate.sv
// Directed self-checking bench for dfir_interpolate (default and hold builds).
`default_nettype none

module tb_dfir_interpolate;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        isConfig = 1'b0;
  logic        isConfigDone;
  logic [23:0] Data_Config_In = '0;
  logic [23:0] Data_In = '0;
  logic        Data_In_Valid = 1'b0;
  logic [3:0]  Data_In_ChIdx = '0;
  logic        Data_In_Ready;
  logic [23:0] Data_Out;
  logic        Data_Out_Valid;
  logic [3:0]  Data_Out_ChIdx;
  logic        Data_Out_Ready = 1'b1;

  int total = 0;
  int passed = 0;

  dfir_interpolate dut (
    .CLK(CLK), .nRST(nRST), .isConfig(isConfig), .isConfigDone(isConfigDone),
    .Data_Config_In(Data_Config_In), .Data_In(Data_In), .Data_In_Valid(Data_In_Valid),
    .Data_In_ChIdx(Data_In_ChIdx), .Data_In_Ready(Data_In_Ready), .Data_Out(Data_Out),
    .Data_Out_Valid(Data_Out_Valid), .Data_Out_ChIdx(Data_Out_ChIdx),
    .Data_Out_Ready(Data_Out_Ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] fill(input logic [23:0] s);
`ifdef DFIR_INTERP_HOLD_EN
    return s;
`else
    return 24'h0;
`endif
  endfunction

  task automatic do_config(input logic [23:0] v);
    @(negedge CLK); isConfig = 1'b1; Data_Config_In = v;
    @(negedge CLK); isConfig = 1'b0; #1;
    total++; if (Data_In_Ready !== 1'b0) $display("FAIL cfg_ready_low: got %b want 0", Data_In_Ready); else passed++;
    total++; if (isConfigDone !== 1'b0) $display("FAIL cfg_done_early: got %b want 0", isConfigDone); else passed++;
    @(negedge CLK); #1;
    total++; if (isConfigDone !== 1'b1) $display("FAIL cfg_done_pulse: got %b want 1", isConfigDone); else passed++;
    @(negedge CLK); #1;
    total++; if (isConfigDone !== 1'b0) $display("FAIL cfg_done_end: got %b want 0", isConfigDone); else passed++;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL cfg_run_ready: got %b want 1", Data_In_Ready); else passed++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", Data_Out_Valid); else passed++;
    total++; if (Data_Out !== 24'h0) $display("FAIL rst_data: got %h want 000000", Data_Out); else passed++;
    total++; if (Data_Out_ChIdx !== 4'h0) $display("FAIL rst_ch: got %h want 0", Data_Out_ChIdx); else passed++;
    total++; if (isConfigDone !== 1'b0) $display("FAIL rst_done: got %b want 0", isConfigDone); else passed++;
    total++; if (Data_In_Ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", Data_In_Ready); else passed++;
    @(negedge CLK); nRST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL rel_ready: got %b want 1", Data_In_Ready); else passed++;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL rel_valid: got %b want 0", Data_Out_Valid); else passed++;
  endtask

  task automatic test_basic();
    logic [23:0] e;
    do_config(24'd3);
    @(negedge CLK); Data_In = 24'h000100; Data_In_ChIdx = 4'd0; Data_In_Valid = 1'b1; #1;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", Data_In_Ready); else passed++;
    @(negedge CLK); Data_In_Valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      #1;
      e = (p == 0) ? 24'h000100 : fill(24'h000100);
      total++; if (Data_Out_Valid !== 1'b1) $display("FAIL basic_valid p%0d: got %b want 1", p, Data_Out_Valid); else passed++;
      total++; if (Data_Out !== e) $display("FAIL basic_data p%0d: got %h want %h", p, Data_Out, e); else passed++;
      total++; if (Data_Out_ChIdx !== 4'd0) $display("FAIL basic_ch p%0d: got %h want 0", p, Data_Out_ChIdx); else passed++;
      @(negedge CLK);
    end
    #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL basic_end: got %b want 0", Data_Out_Valid); else passed++;
  endtask

  task automatic test_stall();
    logic [23:0] e;
    logic        rdy;
    int          cnt;
    do_config(24'd4);
    @(negedge CLK); Data_In = 24'h00ABCD; Data_In_ChIdx = 4'd1; Data_In_Valid = 1'b1;
    @(negedge CLK); Data_In_Valid = 1'b0;
    cnt = 0; rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      Data_Out_Ready = rdy; #1;
      if (Data_Out_Valid) begin
        e = (cnt == 0) ? 24'h00ABCD : fill(24'h00ABCD);
        total++; if (Data_Out !== e) $display("FAIL stall_data c%0d: got %h want %h", c, Data_Out, e); else passed++;
        total++; if (Data_Out_ChIdx !== 4'd1) $display("FAIL stall_ch c%0d: got %h want 1", c, Data_Out_ChIdx); else passed++;
        total++; if (Data_In_Ready !== (rdy && cnt == 3)) $display("FAIL stall_inready c%0d: got %b want %b", c, Data_In_Ready, (rdy && cnt == 3)); else passed++;
        if (rdy) cnt++;
      end
      @(negedge CLK); rdy = !rdy;
    end
    Data_Out_Ready = 1'b1;
    total++; if (cnt !== 4) $display("FAIL stall_count: got %0d want 4", cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    logic        acc;
    int          k, j;
    do_config(24'd2);
    k = 0;
    @(negedge CLK);
    for (int c = 0; c < 13; c++) begin
      Data_In_Valid = (k < 6); Data_In = 24'(k + 1); Data_In_ChIdx = 4'(k % 2); #1;
      total++; if (Data_In_Ready !== (c % 2 == 0)) $display("FAIL b2b_ready c%0d: got %b want %b", c, Data_In_Ready, (c % 2 == 0)); else passed++;
      if (c >= 1) begin
        j = (c - 1) / 2;
        e = ((c - 1) % 2 == 0) ? 24'(j + 1) : fill(24'(j + 1));
        total++; if (Data_Out_Valid !== 1'b1) $display("FAIL b2b_valid c%0d: got %b want 1", c, Data_Out_Valid); else passed++;
        total++; if (Data_Out !== e) $display("FAIL b2b_data c%0d: got %h want %h", c, Data_Out, e); else passed++;
        total++; if (Data_Out_ChIdx !== 4'(j % 2)) $display("FAIL b2b_ch c%0d: got %h want %h", c, Data_Out_ChIdx, 4'(j % 2)); else passed++;
      end
      acc = Data_In_Ready && Data_In_Valid;
      @(negedge CLK);
      if (acc) k++;
    end
    Data_In_Valid = 1'b0; #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", Data_Out_Valid); else passed++;
  endtask

  task automatic test_clamp();
    logic [23:0] e;
    do_config(24'd0);
    @(negedge CLK); Data_In = 24'h123456; Data_In_ChIdx = 4'd0; Data_In_Valid = 1'b1; #1;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL l1_ready0: got %b want 1", Data_In_Ready); else passed++;
    @(negedge CLK); Data_In = 24'h654321; Data_In_ChIdx = 4'd1; #1;
    total++; if (Data_Out !== 24'h123456) $display("FAIL l1_data0: got %h want 123456", Data_Out); else passed++;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL l1_ready1: got %b want 1", Data_In_Ready); else passed++;
    @(negedge CLK); Data_In_Valid = 1'b0; #1;
    total++; if (Data_Out !== 24'h654321) $display("FAIL l1_data1: got %h want 654321", Data_Out); else passed++;
    total++; if (Data_Out_ChIdx !== 4'd1) $display("FAIL l1_ch1: got %h want 1", Data_Out_ChIdx); else passed++;
    @(negedge CLK); #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL l1_end: got %b want 0", Data_Out_Valid); else passed++;
    do_config(24'd9);
    @(negedge CLK); Data_In = 24'h0F0F0F; Data_In_ChIdx = 4'd1; Data_In_Valid = 1'b1;
    @(negedge CLK); Data_In_Valid = 1'b0;
    for (int p = 0; p < 5; p++) begin
      #1;
      e = (p == 0) ? 24'h0F0F0F : fill(24'h0F0F0F);
      total++; if (Data_Out_Valid !== 1'b1) $display("FAIL l5_valid p%0d: got %b want 1", p, Data_Out_Valid); else passed++;
      total++; if (Data_Out !== e) $display("FAIL l5_data p%0d: got %h want %h", p, Data_Out, e); else passed++;
      @(negedge CLK);
    end
    #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL l5_end: got %b want 0", Data_Out_Valid); else passed++;
  endtask

  task automatic test_abort();
    logic [23:0] e;
    @(negedge CLK); Data_In = 24'h000777; Data_In_ChIdx = 4'd1; Data_In_Valid = 1'b1;
    @(negedge CLK); Data_In_Valid = 1'b0; #1;
    total++; if (Data_Out !== 24'h000777) $display("FAIL ab_p0: got %h want 000777", Data_Out); else passed++;
    @(negedge CLK); #1;
    total++; if (Data_Out_Valid !== 1'b1) $display("FAIL ab_p1_valid: got %b want 1", Data_Out_Valid); else passed++;
    isConfig = 1'b1; Data_Config_In = 24'd3;
    @(negedge CLK); isConfig = 1'b0; #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL ab_drop: got %b want 0", Data_Out_Valid); else passed++;
    total++; if (Data_In_Ready !== 1'b0) $display("FAIL ab_ready: got %b want 0", Data_In_Ready); else passed++;
    @(negedge CLK); #1;
    total++; if (isConfigDone !== 1'b1) $display("FAIL ab_done: got %b want 1", isConfigDone); else passed++;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL ab_quiet: got %b want 0", Data_Out_Valid); else passed++;
    @(negedge CLK); Data_In = 24'h000999; Data_In_ChIdx = 4'd0; Data_In_Valid = 1'b1;
    @(negedge CLK); Data_In_Valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      #1;
      e = (p == 0) ? 24'h000999 : fill(24'h000999);
      total++; if (Data_Out_Valid !== 1'b1) $display("FAIL ab_new_valid p%0d: got %b want 1", p, Data_Out_Valid); else passed++;
      total++; if (Data_Out !== e) $display("FAIL ab_new_data p%0d: got %h want %h", p, Data_Out, e); else passed++;
      @(negedge CLK);
    end
    #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL ab_new_end: got %b want 0", Data_Out_Valid); else passed++;
  endtask

  task automatic test_discard_reset();
    @(negedge CLK); Data_In = 24'h0000EE; Data_In_ChIdx = 4'd7; Data_In_Valid = 1'b1; #1;
    total++; if (Data_In_Ready !== 1'b1) $display("FAIL disc_ready: got %b want 1", Data_In_Ready); else passed++;
    @(negedge CLK); Data_In_Valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (Data_Out_Valid !== 1'b0) $display("FAIL disc_valid c%0d: got %b want 0", c, Data_Out_Valid); else passed++;
      @(negedge CLK);
    end
    Data_In = 24'h0000AA; Data_In_ChIdx = 4'd1; Data_In_Valid = 1'b1;
    @(negedge CLK); Data_In_Valid = 1'b0; #1;
    total++; if (Data_Out_Valid !== 1'b1) $display("FAIL mid_valid: got %b want 1", Data_Out_Valid); else passed++;
    @(negedge CLK); #1;
    nRST = 1'b0; #1;
    total++; if (Data_Out_Valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", Data_Out_Valid); else passed++;
    total++; if (Data_Out !== 24'h0) $display("FAIL mid_rst_data: got %h want 000000", Data_Out); else passed++;
    total++; if (Data_Out_ChIdx !== 4'h0) $display("FAIL mid_rst_ch: got %h want 0", Data_Out_ChIdx); else passed++;
    total++; if (Data_In_Ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", Data_In_Ready); else passed++;
    @(negedge CLK); nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      total++; if (Data_Out_Valid !== 1'b0) $display("FAIL post_rst_valid c%0d: got %b want 0", c, Data_Out_Valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_clamp();
    test_abort();
    test_discard_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
